// File: rtl/fwd_track_unit.sv
// Forwarding/hazard tracker beside decode: shadows DEPTH in-flight register writes,
// forwards the youngest ready value to each read port and raises a load-use stall.
module fwd_track_unit #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int NRD   = 2,
  parameter int DEPTH = 3,
  parameter int CNTW  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              issue_en,
  input  logic              issue_wen,
  input  logic [RW-1:0]     issue_wsel,
  input  logic              issue_isload,
  input  logic [DW-1:0]     ex_result,
  input  logic [DW-1:0]     mem_dload,
  input  logic              mem_dhit,
  input  logic              mem_wait,
  input  logic              flush,
  input  logic [NRD-1:0]    rport_valid,
  input  logic [NRD*RW-1:0] rsel,
  input  logic [NRD*DW-1:0] rdat_in,
  output logic [NRD*DW-1:0] rdat_out,
  output logic [NRD-1:0]    fwd_hit,
  output logic              stall,
  output logic [CNTW-1:0]   stall_count
);

  logic [DEPTH-1:0] s_valid;
  logic [DEPTH-1:0] s_isload;
  logic [DEPTH-1:0] s_ready;
  logic [RW-1:0]    s_wsel [DEPTH];
  logic [DW-1:0]    s_data [DEPTH];

  logic             cap1;
  logic             n1_ready;
  logic [DW-1:0]    n1_data;
  logic [NRD-1:0]   need_stall;

  // Slot 1 load data can land while frozen or on the same edge it moves to slot 2.
  assign cap1     = s_valid[1] && s_isload[1] && !s_ready[1] && mem_dhit;
  assign n1_ready = cap1 ? 1'b1 : s_ready[1];
  assign n1_data  = cap1 ? mem_dload : s_data[1];

  assign stall = nRST && issue_en && !flush && ((|need_stall) || mem_wait);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s_valid     <= '0;
      s_isload    <= '0;
      s_ready     <= '0;
      stall_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        s_wsel[k] <= '0;
        s_data[k] <= '0;
      end
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNTW'(1);
      if (!mem_wait) begin
        for (int k = 2; k < DEPTH; k++) begin
          s_valid[k]  <= s_valid[k-1];
          s_isload[k] <= s_isload[k-1];
          s_wsel[k]   <= s_wsel[k-1];
          if (k == 2) begin
            s_ready[k] <= n1_ready;
            s_data[k]  <= n1_data;
          end else begin
            s_ready[k] <= s_ready[k-1];
            s_data[k]  <= s_data[k-1];
          end
        end
        s_valid[1]  <= s_valid[0];
        s_isload[1] <= s_isload[0];
        s_wsel[1]   <= s_wsel[0];
        s_ready[1]  <= !s_isload[0];
        s_data[1]   <= ex_result;
        s_valid[0]  <= issue_en && issue_wen && !stall && !flush;
        s_isload[0] <= issue_isload;
        s_wsel[0]   <= issue_wsel;
        s_ready[0]  <= 1'b0;
        s_data[0]   <= '0;
      end else begin
        s_ready[1] <= n1_ready;
        s_data[1]  <= n1_data;
        if (flush)
          s_valid[0] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [RW-1:0] sel;
    logic [DW-1:0] rd;
    logic          hit;
    logic          need;
    logic          found;

    assign sel = rsel[i*RW +: RW];

    // Scan from slot 0 so the youngest matching writer wins.
    always_comb begin
      rd    = rdat_in[i*DW +: DW];
      hit   = 1'b0;
      need  = 1'b0;
      found = 1'b0;
      if (rport_valid[i] && (sel != '0)) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (!found && s_valid[k] && (s_wsel[k] == sel)) begin
            found = 1'b1;
            if ((k == 0) && !s_isload[0]) begin
              rd  = ex_result;
              hit = 1'b1;
            end else if ((k == 1) && s_isload[1] && !s_ready[1]) begin
              if (mem_dhit) begin
                rd  = mem_dload;
                hit = 1'b1;
              end else begin
                need = 1'b1;
              end
            end else if (s_ready[k]) begin
              rd  = s_data[k];
              hit = 1'b1;
            end else begin
              need = 1'b1;
            end
          end
        end
      end
    end

    assign rdat_out[i*DW +: DW] = rd;
    assign fwd_hit[i]           = hit;
    assign need_stall[i]        = need;
  end

endmodule
